// File: rtl/ssd_pkg.sv
// Shared types and glyph table for the multiplexed seven-segment display driver.
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}, indexed by hex value 0-F
    localparam seg_t GLYPHS [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seven_seg_decoder
    import ssd_pkg::*;
(
    input  logic [3:0] hex,
    output seg_t       seg_c
);

    assign seg_c = GLYPHS[hex];

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit multiplexed seven-segment scanner with dead-time blanking and frame-aligned double buffering.
// Optional leading-zero suppression is built when SSD_LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scanner
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_en,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    input  logic                          load,
    output logic [NUM_DIGITS-1:0]         anode_n,
    output seg_t                          seg_n,
    output logic                          dp_n,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_tick
);

    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam int unsigned PS_W  = $clog2(REFRESH_DIV);
    localparam int unsigned DW    = 4 * NUM_DIGITS;

    logic [PS_W-1:0]       ps_q, ps_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  wrap_c, wrap_q;

    logic [DW-1:0]         pend_digits, act_digits;
    logic [NUM_DIGITS-1:0] pend_dp, act_dp;
    logic [NUM_DIGITS-1:0] pend_en, act_en;
    logic [NUM_DIGITS-1:0] lz_blank;

    logic [3:0]            cur_nib;
    logic                  cur_en, cur_dp, cur_lz;
    seg_t                  cur_glyph;
    phase_t                phase;

    // Prescaler and digit index next state; wrap_c marks the edge where the index returns to 0
    always_comb begin
        ps_d   = ps_q;
        idx_d  = idx_q;
        wrap_c = 1'b0;
        if (!scan_en) begin
            ps_d  = '0;
            idx_d = '0;
        end else if (ps_q == PS_W'(REFRESH_DIV - 1)) begin
            ps_d = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d  = '0;
                wrap_c = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            ps_d = ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q   <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_c;
        end
    end

    // Pending buffer takes every load; active only changes at the frame wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '0;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '0;
        end else begin
            if (load) begin
                pend_digits <= digits_in;
                pend_dp     <= dp_in;
                pend_en     <= digit_en;
            end
            if (wrap_c) begin
                act_digits <= load ? digits_in : pend_digits;
                act_dp     <= load ? dp_in     : pend_dp;
                act_en     <= load ? digit_en  : pend_en;
            end
        end
    end

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // Blank zero digits from the top down until the first non-zero or dp digit; digit 0 always shows
    always_comb begin
        logic seen;
        seen     = 1'b0;
        lz_blank = '0;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            if ((act_digits[4*k +: 4] != 4'h0) || act_dp[k]) begin
                seen = 1'b1;
            end
            lz_blank[k] = !seen;
        end
    end
`else
    assign lz_blank = '0;
`endif

    assign cur_nib = act_digits[{idx_q, 2'b00} +: 4];
    assign cur_en  = act_en[idx_q];
    assign cur_dp  = act_dp[idx_q];
    assign cur_lz  = lz_blank[idx_q];
    assign phase   = (ps_q < PS_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;

    seven_seg_decoder u_dec (
        .hex   (cur_nib),
        .seg_c (cur_glyph)
    );

    // Pin registers: one cycle behind the prescaler/index state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anode_n    <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else if (!scan_en) begin
            anode_n    <= '1;
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            digit_idx  <= idx_q;
            frame_tick <= wrap_q;
            if (phase == PH_BLANK) begin
                anode_n <= '1;
                seg_n   <= SEG_BLANK;
                dp_n    <= 1'b1;
            end else begin
                // Disabled digits keep their anode for uniform duty cycle but show nothing
                anode_n <= ~(NUM_DIGITS'(1) << idx_q);
                seg_n   <= (cur_en && !cur_lz) ? cur_glyph : SEG_BLANK;
                dp_n    <= !(cur_en && cur_dp);
            end
        end
    end

endmodule
